stopwatch_ctrl: RTL and testbench

Control FSM for the stopwatch counter chain. It turns debounced button pulses into the chain's count-enable and clear, and captures lap times into a small circular buffer. It also drives the live or frozen time toward the 7-segment scan mux. It sits between the debounce/clock-divider blocks and the BCD/mod-6 counter chain.

---
 rtl/stopwatch_pkg.sv | 26 ++
 rtl/stopwatch_ctrl_lap_buffer.sv | 74 +++++++
 rtl/stopwatch_ctrl.sv | 156 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control slice.
//   state_e         : control FSM states
//   DefTimeW        : packed time width, 8 BCD digits, digit 7 in [31:28]
//   MaxTime         : 99:59:59.99 terminal time value
//   DefHoldTicks    : default 100 Hz ticks the display stays frozen after a lap
//   DefLapDepth     : default number of lap entries
package stopwatch_pkg;

  localparam int unsigned DefTimeW     = 32;
  localparam int unsigned DefHoldTicks = 200;
  localparam int unsigned DefLapDepth  = 4;
  localparam logic [31:0] MaxTime      = 32'h9959_5999;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StLapHold = 2'd2,
    StStop    = 2'd3
  } state_e;

  // Counting states: the chain is enabled and laps may be captured.
  function automatic logic is_counting(state_e s);
    return (s == StRun) || (s == StLapHold);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_lap_buffer.sv
// Circular lap register file.
//   clk_i, reset_i : clock, synchronous active-high reset
//   clr_i          : drop all stored laps (pointer and count back to 0)
//   wr_en_i        : store wr_data_i at the write pointer, then advance it
//   rd_addr_i      : read index, 0 = newest entry
//   rd_data_o      : registered entry, 0 when rd_addr_i >= count
//   newest_o       : most recently written entry, combinational
//   count_o        : laps stored, saturating at Depth
module lap_buffer
  import stopwatch_pkg::*;
#(
  parameter int unsigned Depth = DefLapDepth,
  parameter int unsigned Width = DefTimeW
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     clr_i,
  input  logic                     wr_en_i,
  input  logic [Width-1:0]         wr_data_i,
  input  logic [$clog2(Depth)-1:0] rd_addr_i,
  output logic [Width-1:0]         rd_data_o,
  output logic [Width-1:0]         newest_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AW   = $clog2(Depth);
  localparam int unsigned CntW = AW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wptr_q;
  logic [CntW-1:0]  count_q;
  logic [Width-1:0] rd_data_q;
  logic [AW-1:0]    newest_idx;
  logic [AW-1:0]    rd_idx;

  // Depth is a power of two, so pointer arithmetic wraps for free.
  assign newest_idx = wptr_q - AW'(1);
  assign rd_idx     = newest_idx - rd_addr_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q    <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (clr_i) begin
        wptr_q  <= '0;
        count_q <= '0;
      end else if (wr_en_i) begin
        wptr_q <= wptr_q + AW'(1);
        if (count_q != CntW'(Depth)) begin
          count_q <= count_q + CntW'(1);
        end
      end
      if ({1'b0, rd_addr_i} < count_q) begin
        rd_data_q <= mem_q[rd_idx];
      end else begin
        rd_data_q <= '0;
      end
    end
  end

  // Storage needs no reset: entries beyond count are never read out.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !reset_i && !clr_i) begin
      mem_q[wptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = rd_data_q;
  assign newest_o  = mem_q[newest_idx];
  assign count_o   = count_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: turns debounced button pulses into count-enable and
// clear for the BCD counter chain, captures lap times and drives the display.
// Optional feature macro: STOPWATCH_AUTO_STOP_EN (stop at MaxTime instead of
// wrapping).
//   clk_i, reset_i   : clock, synchronous active-high reset
//   tick_100hz_i     : one-cycle 100 Hz pulse from the clock divider
//   btn_ss_i         : start/stop pulse
//   btn_lap_i        : lap/clear pulse
//   time_bcd_i       : live counter chain value
//   cnt_ovf_i        : terminal-count pulse from the last digit
//   cnt_en_o         : gated tick to the first counter (combinational)
//   cnt_clr_o        : one-cycle clear to all counters
//   disp_bcd_o       : value to the display mux (live, or newest lap in hold)
//   running_o        : high in RUN or LAP_HOLD
//   lap_cnt_o        : laps stored, saturating
//   lap_rd_addr_i    : lap read index, 0 = newest
//   lap_rd_data_o    : lap entry, 1-cycle latency
//   ovf_flag_o       : sticky overflow indicator
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned LapDepth  = DefLapDepth,
  parameter int unsigned HoldTicks = DefHoldTicks,
  parameter int unsigned TimeW     = DefTimeW
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        tick_100hz_i,
  input  logic                        btn_ss_i,
  input  logic                        btn_lap_i,
  input  logic [TimeW-1:0]            time_bcd_i,
  input  logic                        cnt_ovf_i,
  output logic                        cnt_en_o,
  output logic                        cnt_clr_o,
  output logic [TimeW-1:0]            disp_bcd_o,
  output logic                        running_o,
  output logic [$clog2(LapDepth):0]   lap_cnt_o,
  input  logic [$clog2(LapDepth)-1:0] lap_rd_addr_i,
  output logic [TimeW-1:0]            lap_rd_data_o,
  output logic                        ovf_flag_o
);

  localparam int unsigned HoldW = $clog2(HoldTicks + 1);

  state_e            state_q, state_d;
  logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
  logic              cnt_clr_q;
  logic              running_q;
  logic              ovf_flag_q;
  logic [TimeW-1:0]  disp_q;

  logic              counting;
  logic              lap_ev;
  logic              lap_wr;
  logic              lap_clr;
  logic              at_max;
  logic              ovf_set;
  logic [TimeW-1:0]  newest_lap;

  assign counting = is_counting(state_q);
  // Start/stop wins over lap when both arrive together.
  assign lap_ev   = btn_lap_i & ~btn_ss_i;

`ifdef STOPWATCH_AUTO_STOP_EN
  assign at_max  = counting & tick_100hz_i & (time_bcd_i == TimeW'(MaxTime));
  assign ovf_set = at_max;
`else
  assign at_max  = 1'b0;
  assign ovf_set = counting & cnt_ovf_i;
`endif

  // Straight from the state register: a tick alongside a stop still counts.
  assign cnt_en_o = tick_100hz_i & counting & ~at_max;
  assign lap_wr   = lap_ev & counting & ~at_max & ~reset_i;
  assign lap_clr  = lap_ev & (state_q == StStop);

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (btn_ss_i) state_d = StRun;
      end
      StRun: begin
        if (btn_ss_i || at_max) begin
          state_d = StStop;
        end else if (lap_ev) begin
          state_d    = StLapHold;
          hold_cnt_d = '0;
        end
      end
      StLapHold: begin
        if (btn_ss_i || at_max) begin
          state_d = StStop;
        end else if (lap_ev) begin
          hold_cnt_d = '0;
        end else if (tick_100hz_i) begin
          // Leave on the tick that brings the count to HoldTicks.
          if (hold_cnt_q == HoldW'(HoldTicks - 1)) state_d = StRun;
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      StStop: begin
        if (btn_ss_i) begin
          state_d = StRun;
        end else if (lap_ev) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      cnt_clr_q  <= 1'b0;
      running_q  <= 1'b0;
      ovf_flag_q <= 1'b0;
      disp_q     <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      cnt_clr_q  <= lap_clr;
      running_q  <= is_counting(state_d);
      if (lap_clr) begin
        ovf_flag_q <= 1'b0;
      end else if (ovf_set) begin
        ovf_flag_q <= 1'b1;
      end
      disp_q <= (state_q == StLapHold) ? newest_lap : time_bcd_i;
    end
  end

  lap_buffer #(
    .Depth (LapDepth),
    .Width (TimeW)
  ) u_lap_buffer (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clr_i     (lap_clr),
    .wr_en_i   (lap_wr),
    .wr_data_i (time_bcd_i),
    .rd_addr_i (lap_rd_addr_i),
    .rd_data_o (lap_rd_data_o),
    .newest_o  (newest_lap),
    .count_o   (lap_cnt_o)
  );

  assign cnt_clr_o  = cnt_clr_q;
  assign running_o  = running_q;
  assign ovf_flag_o = ovf_flag_q;
  assign disp_bcd_o = disp_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl (default parameters).
module tb_stopwatch_ctrl;

  logic        clk;
  logic        reset;
  logic        tick_100hz;
  logic        btn_ss;
  logic        btn_lap;
  logic [31:0] time_bcd;
  logic        cnt_ovf;
  logic        cnt_en;
  logic        cnt_clr;
  logic [31:0] disp_bcd;
  logic        running;
  logic [2:0]  lap_cnt;
  logic [1:0]  lap_rd_addr;
  logic [31:0] lap_rd_data;
  logic        ovf_flag;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .tick_100hz_i  (tick_100hz),
    .btn_ss_i      (btn_ss),
    .btn_lap_i     (btn_lap),
    .time_bcd_i    (time_bcd),
    .cnt_ovf_i     (cnt_ovf),
    .cnt_en_o      (cnt_en),
    .cnt_clr_o     (cnt_clr),
    .disp_bcd_o    (disp_bcd),
    .running_o     (running),
    .lap_cnt_o     (lap_cnt),
    .lap_rd_addr_i (lap_rd_addr),
    .lap_rd_data_o (lap_rd_data),
    .ovf_flag_o    (ovf_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One clock: apply pulses, sample cnt_en before the edge, release after it.
  task automatic step(input logic ss, input logic lap, input logic tk, input logic ovf,
                      output logic en);
    btn_ss     = ss;
    btn_lap    = lap;
    tick_100hz = tk;
    cnt_ovf    = ovf;
    #2 en = cnt_en;
    @(posedge clk);
    #1;
    btn_ss     = 1'b0;
    btn_lap    = 1'b0;
    tick_100hz = 1'b0;
    cnt_ovf    = 1'b0;
  endtask

  task automatic test_reset();
    logic en;
    reset       = 1'b1;
    time_bcd    = 32'h0000_1234;
    lap_rd_addr = 2'd0;
    step(1'b1, 1'b1, 1'b1, 1'b1, en);
    step(1'b1, 1'b0, 1'b1, 1'b0, en);
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL reset_cnt_en: got %0b expected 0", en); end
    checks++; if (cnt_clr !== 1'b0) begin errors++; $display("FAIL reset_cnt_clr: got %0b expected 0", cnt_clr); end
    checks++; if (disp_bcd !== 32'h0) begin errors++; $display("FAIL reset_disp: got %h expected 0", disp_bcd); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %0b expected 0", running); end
    checks++; if (lap_cnt !== 3'd0) begin errors++; $display("FAIL reset_lap_cnt: got %0d expected 0", lap_cnt); end
    checks++; if (lap_rd_data !== 32'h0) begin errors++; $display("FAIL reset_lap_rd: got %h expected 0", lap_rd_data); end
    checks++; if (ovf_flag !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", ovf_flag); end
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b0, en);
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL idle_cnt_en: got %0b expected 0", en); end
    checks++; if (disp_bcd !== 32'h0000_1234) begin errors++; $display("FAIL idle_disp: got %h expected 00001234", disp_bcd); end
  endtask

  task automatic test_start_stop();
    logic en;
    int   en_cnt;
    en_cnt = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0, en);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL ss_start_running: got %0b expected 1", running); end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, en);
      en_cnt += int'(en);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, en);
    en_cnt += int'(en);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL ss_stop_running: got %0b expected 0", running); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, en);
      en_cnt += int'(en);
    end
    checks++; if (en_cnt != 5) begin errors++; $display("FAIL ss_en_pulses: got %0d expected 5", en_cnt); end
  endtask

  task automatic test_simultaneous();
    logic en;
    step(1'b1, 1'b0, 1'b0, 1'b0, en);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL simul_run: got %0b expected 1", running); end
    time_bcd = 32'h0000_0777;
    step(1'b1, 1'b1, 1'b0, 1'b0, en);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL simul_stop: got %0b expected 0", running); end
    checks++; if (lap_cnt !== 3'd0) begin errors++; $display("FAIL simul_lap_cnt: got %0d expected 0", lap_cnt); end
    checks++; if (cnt_clr !== 1'b0) begin errors++; $display("FAIL simul_clr: got %0b expected 0", cnt_clr); end
    lap_rd_addr = 2'd0;
    step(1'b0, 1'b0, 1'b0, 1'b0, en);
    checks++; if (lap_rd_data !== 32'h0) begin errors++; $display("FAIL simul_rd: got %h expected 0", lap_rd_data); end
  endtask

  task automatic test_lap_hold();
    logic en;
    int   en_cnt;
    en_cnt = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0, en);
    time_bcd = 32'h0000_0123;
    step(1'b0, 1'b1, 1'b0, 1'b0, en);
    checks++; if (lap_cnt !== 3'd1) begin errors++; $display("FAIL lap_cnt1: got %0d expected 1", lap_cnt); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL lap_running: got %0b expected 1", running); end
    time_bcd = 32'h0000_0456;
    step(1'b0, 1'b0, 1'b0, 1'b0, en);
    checks++; if (disp_bcd !== 32'h0000_0123) begin errors++; $display("FAIL lap_disp_frozen: got %h expected 00000123", disp_bcd); end
    checks++; if (lap_rd_data !== 32'h0000_0123) begin errors++; $display("FAIL lap_rd0: got %h expected 00000123", lap_rd_data); end
    for (int i = 0; i < 199; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, en);
      en_cnt += int'(en);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, en);
    checks++; if (disp_bcd !== 32'h0000_0123) begin errors++; $display("FAIL lap_disp_199: got %h expected 00000123", disp_bcd); end
    step(1'b0, 1'b0, 1'b1, 1'b0, en);
    en_cnt += int'(en);
    step(1'b0, 1'b0, 1'b0, 1'b0, en);
    checks++; if (disp_bcd !== 32'h0000_0456) begin errors++; $display("FAIL lap_disp_live: got %h expected 00000456", disp_bcd); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL lap_back_run: got %0b expected 1", running); end
    checks++; if (en_cnt != 200) begin errors++; $display("FAIL lap_hold_en: got %0d expected 200", en_cnt); end
  endtask

  task automatic test_buffer_wrap();
    logic        en;
    logic [31:0] exp_v;
    for (int v = 1; v <= 6; v++) begin
      time_bcd = 32'(v);
      step(1'b0, 1'b1, 1'b0, 1'b0, en);
    end
    checks++; if (lap_cnt !== 3'd4) begin errors++; $display("FAIL wrap_lap_cnt: got %0d expected 4", lap_cnt); end
    time_bcd = 32'h0000_0999;
    for (int a = 0; a < 4; a++) begin
      lap_rd_addr = 2'(a);
      exp_v       = 32'(6 - a);
      step(1'b0, 1'b0, 1'b0, 1'b0, en);
      checks++;
      if (lap_rd_data !== exp_v) begin
        errors++;
        $display("FAIL wrap_rd_addr%0d: got %h expected %h", a, lap_rd_data, exp_v);
      end
    end
    lap_rd_addr = 2'd0;
    checks++; if (disp_bcd !== 32'h0000_0006) begin errors++; $display("FAIL wrap_disp_newest: got %h expected 00000006", disp_bcd); end
  endtask

  task automatic test_hold_cancel();
    logic en;
    time_bcd = 32'h0000_0ABC;
    step(1'b1, 1'b0, 1'b0, 1'b0, en);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL cancel_running: got %0b expected 0", running); end
    step(1'b0, 1'b0, 1'b0, 1'b0, en);
    checks++; if (disp_bcd !== 32'h0000_0ABC) begin errors++; $display("FAIL cancel_disp_live: got %h expected 00000abc", disp_bcd); end
  endtask

  task automatic test_overflow();
    logic en;
    step(1'b0, 1'b0, 1'b0, 1'b1, en);
    checks++; if (ovf_flag !== 1'b0) begin errors++; $display("FAIL ovf_stopped: got %0b expected 0", ovf_flag); end
    step(1'b1, 1'b0, 1'b0, 1'b0, en);
    time_bcd = 32'h9959_5999;
`ifdef STOPWATCH_AUTO_STOP_EN
    step(1'b0, 1'b0, 1'b1, 1'b0, en);
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL ovf_auto_en: got %0b expected 0", en); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL ovf_auto_stop: got %0b expected 0", running); end
    checks++; if (ovf_flag !== 1'b1) begin errors++; $display("FAIL ovf_auto_flag: got %0b expected 1", ovf_flag); end
    step(1'b0, 1'b0, 1'b0, 1'b0, en);
    checks++; if (disp_bcd !== 32'h9959_5999) begin errors++; $display("FAIL ovf_auto_disp: got %h expected 99595999", disp_bcd); end
`else
    step(1'b0, 1'b0, 1'b1, 1'b1, en);
    checks++; if (en !== 1'b1) begin errors++; $display("FAIL ovf_wrap_en: got %0b expected 1", en); end
    checks++; if (ovf_flag !== 1'b1) begin errors++; $display("FAIL ovf_wrap_flag: got %0b expected 1", ovf_flag); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL ovf_wrap_running: got %0b expected 1", running); end
    time_bcd = 32'h0;
    step(1'b1, 1'b0, 1'b0, 1'b0, en);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL ovf_wrap_stop: got %0b expected 0", running); end
`endif
  endtask

  task automatic test_clear();
    logic en;
    step(1'b0, 1'b1, 1'b0, 1'b0, en);
    checks++; if (cnt_clr !== 1'b1) begin errors++; $display("FAIL clr_pulse: got %0b expected 1", cnt_clr); end
    checks++; if (lap_cnt !== 3'd0) begin errors++; $display("FAIL clr_lap_cnt: got %0d expected 0", lap_cnt); end
    checks++; if (ovf_flag !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %0b expected 0", ovf_flag); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL clr_running: got %0b expected 0", running); end
    step(1'b0, 1'b0, 1'b0, 1'b0, en);
    checks++; if (cnt_clr !== 1'b0) begin errors++; $display("FAIL clr_one_cycle: got %0b expected 0", cnt_clr); end
    checks++; if (lap_rd_data !== 32'h0) begin errors++; $display("FAIL clr_rd: got %h expected 0", lap_rd_data); end
    step(1'b0, 1'b1, 1'b0, 1'b0, en);
    checks++; if (cnt_clr !== 1'b0) begin errors++; $display("FAIL idle_lap_clr: got %0b expected 0", cnt_clr); end
    checks++; if (lap_cnt !== 3'd0) begin errors++; $display("FAIL idle_lap_cnt: got %0d expected 0", lap_cnt); end
    step(1'b0, 1'b0, 1'b1, 1'b0, en);
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL idle_tick_en: got %0b expected 0", en); end
    step(1'b1, 1'b0, 1'b0, 1'b0, en);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL idle_to_run: got %0b expected 1", running); end
  endtask

  task automatic test_reset_capture();
    logic en;
    time_bcd = 32'h0000_0055;
    reset    = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b0, en);
    reset = 1'b0;
    checks++; if (lap_cnt !== 3'd0) begin errors++; $display("FAIL rstcap_lap_cnt: got %0d expected 0", lap_cnt); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL rstcap_running: got %0b expected 0", running); end
    step(1'b0, 1'b0, 1'b0, 1'b0, en);
    checks++; if (lap_rd_data !== 32'h0) begin errors++; $display("FAIL rstcap_rd: got %h expected 0", lap_rd_data); end
  endtask

  initial begin
    reset       = 1'b1;
    tick_100hz  = 1'b0;
    btn_ss      = 1'b0;
    btn_lap     = 1'b0;
    cnt_ovf     = 1'b0;
    time_bcd    = 32'h0;
    lap_rd_addr = 2'd0;
    test_reset();
    test_start_stop();
    test_simultaneous();
    test_lap_hold();
    test_buffer_wrap();
    test_hold_cancel();
    test_overflow();
    test_clear();
    test_reset_capture();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
